// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select and load-use stall controller for the miniRISC EX stage.
// Optional stall_count statistics port is built when FWD_STALL_CNT_EN is defined.
module fwd_hazard_ctrl #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr_en,
  input  logic              id_is_load,
  input  logic              flush,
`ifdef FWD_STALL_CNT_EN
  output logic [31:0]       stall_count,
`endif
  output logic              stall,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b
);

  localparam logic [1:0] SelRegFile = 2'b00;
  localparam logic [1:0] SelExMem   = 2'b01;
  localparam logic [1:0] SelMemWb   = 2'b10;

  logic              exValid_q, exValid_d;
  logic [REG_AW-1:0] exRs_q, exRs_d;
  logic [REG_AW-1:0] exRt_q, exRt_d;
  logic              exRsUsed_q, exRsUsed_d;
  logic              exRtUsed_q, exRtUsed_d;
  logic [REG_AW-1:0] exRd_q, exRd_d;
  logic              exWr_q, exWr_d;
  logic              exLoad_q, exLoad_d;
  logic              memValid_q, memWr_q;
  logic [REG_AW-1:0] memRd_q;
  logic              wbValid_q, wbWr_q;
  logic [REG_AW-1:0] wbRd_q;
  logic              exAccept;

  // r0 is hardwired to zero, so a producer targeting it never forwards.
  function automatic logic writesReg(input logic v, input logic wr,
                                     input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] r);
    return v && wr && (rd == r) && (r != '0);
  endfunction

  always_comb begin
    stall = 1'b0;
    if (id_valid && exValid_q && exLoad_q && exWr_q && (exRd_q != '0) && !flush &&
        ((id_rs_used && (id_rs == exRd_q)) || (id_rt_used && (id_rt == exRd_q))))
      stall = 1'b1;
  end

  always_comb begin
    exAccept   = id_valid && !stall && !flush;
    exValid_d  = exAccept;
    exRs_d     = exAccept ? id_rs : '0;
    exRt_d     = exAccept ? id_rt : '0;
    exRsUsed_d = exAccept && id_rs_used;
    exRtUsed_d = exAccept && id_rt_used;
    exRd_d     = exAccept ? id_rd : '0;
    exWr_d     = exAccept && id_wr_en;
    exLoad_d   = exAccept && id_is_load;
  end

  // The MEM producer is younger than WB, so it takes priority on a double match.
  always_comb begin
    fwd_sel_a = SelRegFile;
    fwd_sel_b = SelRegFile;
    if (exValid_q && exRsUsed_q) begin
      if (writesReg(memValid_q, memWr_q, memRd_q, exRs_q))
        fwd_sel_a = SelExMem;
      else if (writesReg(wbValid_q, wbWr_q, wbRd_q, exRs_q))
        fwd_sel_a = SelMemWb;
    end
    if (exValid_q && exRtUsed_q) begin
      if (writesReg(memValid_q, memWr_q, memRd_q, exRt_q))
        fwd_sel_b = SelExMem;
      else if (writesReg(wbValid_q, wbWr_q, wbRd_q, exRt_q))
        fwd_sel_b = SelMemWb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exValid_q  <= 1'b0;
      exRs_q     <= '0;
      exRt_q     <= '0;
      exRsUsed_q <= 1'b0;
      exRtUsed_q <= 1'b0;
      exRd_q     <= '0;
      exWr_q     <= 1'b0;
      exLoad_q   <= 1'b0;
      memValid_q <= 1'b0;
      memWr_q    <= 1'b0;
      memRd_q    <= '0;
      wbValid_q  <= 1'b0;
      wbWr_q     <= 1'b0;
      wbRd_q     <= '0;
    end else begin
      exValid_q  <= exValid_d;
      exRs_q     <= exRs_d;
      exRt_q     <= exRt_d;
      exRsUsed_q <= exRsUsed_d;
      exRtUsed_q <= exRtUsed_d;
      exRd_q     <= exRd_d;
      exWr_q     <= exWr_d;
      exLoad_q   <= exLoad_d;
      memValid_q <= exValid_q;
      memWr_q    <= exWr_q;
      memRd_q    <= exRd_q;
      wbValid_q  <= memValid_q;
      wbWr_q     <= memWr_q;
      wbRd_q     <= memRd_q;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stallCount_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stallCount_q <= '0;
    else if (stall)
      stallCount_q <= stallCount_q + 32'd1;
  end

  assign stall_count = stallCount_q;
`endif

endmodule
